// File: rtl/ppu_pkg.sv
// Shared PPU-side types, address map and helpers for the VRAM/OAM arbiter.
package ppu_pkg;

    typedef enum logic [1:0] {
        H_BLANK = 2'd0,
        V_BLANK = 2'd1,
        SCAN    = 2'd2,
        DRAW    = 2'd3
    } PPU_STATES_t;

    typedef enum logic [1:0] {
        DMA_IDLE  = 2'd0,
        DMA_DELAY = 2'd1,
        DMA_READ  = 2'd2,
        DMA_WRITE = 2'd3
    } dma_state_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_VRAM = 2'd1,
        SRC_OAM  = 2'd2
    } rd_src_t;

    localparam logic [15:0] VRAM_BASE = 16'h8000;
    localparam logic [15:0] VRAM_END  = 16'h9FFF;
    localparam logic [15:0] OAM_BASE  = 16'hFE00;
    localparam logic [15:0] OAM_END   = 16'hFE9F;
    localparam logic [15:0] DMA_REG   = 16'hFF46;

    function automatic logic in_range(input logic [15:0] a, input logic [15:0] lo,
                                      input logic [15:0] hi);
        return (a >= lo) && (a <= hi);
    endfunction

    // Echo RAM pages E0-FF alias work RAM C0-DF.
    function automatic logic [7:0] dma_src_page(input logic [7:0] p);
        return (p >= 8'hE0) ? (p - 8'h20) : p;
    endfunction

endpackage

// File: rtl/vram_oam_arbiter_if.sv
// CPU-side bus bundle of the VRAM/OAM arbiter; snoop is for blocks that only watch writes.
interface vram_oam_arbiter_if;
    logic [15:0] addr;
    logic        rd;
    logic        wr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;

    modport master (output addr, rd, wr, wdata, input rdata);
    modport slave  (input addr, rd, wr, wdata, output rdata);
    modport snoop  (input addr, wr, wdata);
endinterface

// File: rtl/oam_dma_engine.sv
// OAM DMA engine: copies OAM_BYTES bytes from {page, idx} into OAM after an FF46 write.
module oam_dma_engine #(
    parameter int unsigned OAM_BYTES = 160,
    parameter int unsigned DMA_DELAY = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    vram_oam_arbiter_if.snoop        cpu,
    output logic                     dma_rd_o,
    output logic [15:0]              dma_addr_o,
    input  logic [7:0]               dma_data_i,
    output logic                     oam_wr_o,
    output logic [7:0]               oam_addr_o,
    output logic [7:0]               oam_wdata_o,
    output logic                     active_o
);
    localparam logic [7:0] LastIdx  = 8'(OAM_BYTES - 1);
    localparam logic [7:0] LastWait = 8'(DMA_DELAY - 1);
    localparam ppu_pkg::dma_state_t FirstSt =
        (DMA_DELAY == 0) ? ppu_pkg::DMA_READ : ppu_pkg::DMA_DELAY;

    ppu_pkg::dma_state_t state_q, state_d;
    logic [7:0] idx_q, idx_d, page_q, page_d, wait_q, wait_d;
    logic       start;

    assign start = cpu.wr && (cpu.addr == ppu_pkg::DMA_REG);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        page_d  = page_q;
        wait_d  = wait_q;
        // A new FF46 write restarts even an in-flight transfer.
        if (start) begin
            state_d = FirstSt;
            idx_d   = 8'h00;
            page_d  = ppu_pkg::dma_src_page(cpu.wdata);
            wait_d  = 8'h00;
        end else begin
            unique case (state_q)
                ppu_pkg::DMA_IDLE: ;
                ppu_pkg::DMA_DELAY: begin
                    if (wait_q == LastWait) state_d = ppu_pkg::DMA_READ;
                    else                    wait_d  = wait_q + 8'h01;
                end
                ppu_pkg::DMA_READ: state_d = ppu_pkg::DMA_WRITE;
                ppu_pkg::DMA_WRITE: begin
                    idx_d   = idx_q + 8'h01;
                    state_d = (idx_q == LastIdx) ? ppu_pkg::DMA_IDLE : ppu_pkg::DMA_READ;
                end
                default: state_d = ppu_pkg::DMA_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ppu_pkg::DMA_IDLE;
            idx_q   <= 8'h00;
            page_q  <= 8'h00;
            wait_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            page_q  <= page_d;
            wait_q  <= wait_d;
        end
    end

    assign dma_rd_o    = (state_q == ppu_pkg::DMA_READ);
    assign dma_addr_o  = dma_rd_o ? {page_q, idx_q} : 16'h0000;
    assign oam_wr_o    = (state_q == ppu_pkg::DMA_WRITE);
    assign oam_addr_o  = oam_wr_o ? idx_q : 8'h00;
    assign oam_wdata_o = oam_wr_o ? dma_data_i : 8'h00;
    assign active_o    = (state_q != ppu_pkg::DMA_IDLE);

endmodule

// File: rtl/vram_oam_arbiter.sv
// VRAM/OAM arbiter between CPU, PPU and OAM DMA. Define OAM_DMA_EN to build the DMA engine.
module vram_oam_arbiter #(
    parameter int unsigned OAM_BYTES = 160,
    parameter int unsigned DMA_DELAY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        LCD_EN,
    input  logic [1:0]  PPU_MODE,
    input  logic [15:0] CPU_ADDR,
    input  logic        CPU_RD,
    input  logic        CPU_WR,
    input  logic [7:0]  CPU_DATA_out,
    output logic [7:0]  CPU_DATA_in,
    input  logic [15:0] PPU_ADDR,
    input  logic        PPU_RD,
    output logic [7:0]  PPU_DATA_in,
    output logic [12:0] VRAM_ADDR,
    output logic        VRAM_WR,
    output logic [7:0]  VRAM_WDATA,
    input  logic [7:0]  VRAM_RDATA,
    output logic [7:0]  OAM_ADDR,
    output logic        OAM_WR,
    output logic [7:0]  OAM_WDATA,
    input  logic [7:0]  OAM_RDATA,
    output logic [15:0] DMA_ADDR,
    output logic        DMA_RD,
    input  logic [7:0]  DMA_DATA_in,
    output logic        DMA_ACTIVE
);
    vram_oam_arbiter_if cpu_bus ();

    assign cpu_bus.addr  = CPU_ADDR;
    assign cpu_bus.rd    = CPU_RD;
    assign cpu_bus.wr    = CPU_WR;
    assign cpu_bus.wdata = CPU_DATA_out;
    assign CPU_DATA_in   = cpu_bus.rdata;

    ppu_pkg::PPU_STATES_t ppu_mode;
    ppu_pkg::rd_src_t     cpu_src_q, cpu_src_d, ppu_src_q, ppu_src_d;
    logic        dma_active, dma_oam_wr;
    logic [7:0]  dma_oam_addr, dma_oam_wdata;
    logic        vram_ppu_own, oam_ppu_own;
    logic        cpu_vram_ok, cpu_oam_ok, ppu_vram_ok, ppu_oam_ok;

    assign ppu_mode = ppu_pkg::PPU_STATES_t'(PPU_MODE);

`ifdef OAM_DMA_EN
    oam_dma_engine #(
        .OAM_BYTES (OAM_BYTES),
        .DMA_DELAY (DMA_DELAY)
    ) u_dma (
        .clk         (clk),
        .rst         (rst),
        .cpu         (cpu_bus),
        .dma_rd_o    (DMA_RD),
        .dma_addr_o  (DMA_ADDR),
        .dma_data_i  (DMA_DATA_in),
        .oam_wr_o    (dma_oam_wr),
        .oam_addr_o  (dma_oam_addr),
        .oam_wdata_o (dma_oam_wdata),
        .active_o    (dma_active)
    );
`else
    logic unused_dma;
    assign unused_dma    = ^{DMA_DATA_in, 32'(OAM_BYTES + DMA_DELAY)};
    assign DMA_RD        = 1'b0;
    assign DMA_ADDR      = 16'h0000;
    assign dma_active    = 1'b0;
    assign dma_oam_wr    = 1'b0;
    assign dma_oam_addr  = 8'h00;
    assign dma_oam_wdata = 8'h00;
`endif

    assign DMA_ACTIVE   = dma_active;
    assign vram_ppu_own = LCD_EN && (ppu_mode == ppu_pkg::DRAW);
    assign oam_ppu_own  = LCD_EN && ((ppu_mode == ppu_pkg::SCAN) || (ppu_mode == ppu_pkg::DRAW));

    // "ok" = address hits the region and the requester currently owns it.
    assign cpu_vram_ok = !vram_ppu_own &&
                         ppu_pkg::in_range(cpu_bus.addr, ppu_pkg::VRAM_BASE, ppu_pkg::VRAM_END);
    assign cpu_oam_ok  = !dma_active && !oam_ppu_own &&
                         ppu_pkg::in_range(cpu_bus.addr, ppu_pkg::OAM_BASE, ppu_pkg::OAM_END);
    assign ppu_vram_ok = vram_ppu_own &&
                         ppu_pkg::in_range(PPU_ADDR, ppu_pkg::VRAM_BASE, ppu_pkg::VRAM_END);
    assign ppu_oam_ok  = !dma_active && oam_ppu_own &&
                         ppu_pkg::in_range(PPU_ADDR, ppu_pkg::OAM_BASE, ppu_pkg::OAM_END);

    always_comb begin
        VRAM_ADDR  = 13'h0000;
        VRAM_WR    = 1'b0;
        VRAM_WDATA = 8'h00;
        if (ppu_vram_ok && PPU_RD) begin
            VRAM_ADDR = PPU_ADDR[12:0];
        end else if (cpu_vram_ok && (cpu_bus.rd || cpu_bus.wr)) begin
            VRAM_ADDR  = cpu_bus.addr[12:0];
            VRAM_WR    = cpu_bus.wr;
            VRAM_WDATA = cpu_bus.wr ? cpu_bus.wdata : 8'h00;
        end
    end

    always_comb begin
        OAM_ADDR  = 8'h00;
        OAM_WR    = 1'b0;
        OAM_WDATA = 8'h00;
        if (dma_active) begin
            OAM_ADDR  = dma_oam_addr;
            OAM_WR    = dma_oam_wr;
            OAM_WDATA = dma_oam_wdata;
        end else if (ppu_oam_ok && PPU_RD) begin
            OAM_ADDR = PPU_ADDR[7:0];
        end else if (cpu_oam_ok && (cpu_bus.rd || cpu_bus.wr)) begin
            OAM_ADDR  = cpu_bus.addr[7:0];
            OAM_WR    = cpu_bus.wr;
            OAM_WDATA = cpu_bus.wr ? cpu_bus.wdata : 8'h00;
        end
    end

    // Read source is frozen on the strobe cycle so a mode flip cannot swap the data.
    always_comb begin
        cpu_src_d = ppu_pkg::SRC_NONE;
        ppu_src_d = ppu_pkg::SRC_NONE;
        if (cpu_bus.rd && cpu_vram_ok)     cpu_src_d = ppu_pkg::SRC_VRAM;
        else if (cpu_bus.rd && cpu_oam_ok) cpu_src_d = ppu_pkg::SRC_OAM;
        if (PPU_RD && ppu_vram_ok)         ppu_src_d = ppu_pkg::SRC_VRAM;
        else if (PPU_RD && ppu_oam_ok)     ppu_src_d = ppu_pkg::SRC_OAM;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_src_q <= ppu_pkg::SRC_NONE;
            ppu_src_q <= ppu_pkg::SRC_NONE;
        end else begin
            cpu_src_q <= cpu_src_d;
            ppu_src_q <= ppu_src_d;
        end
    end

    always_comb begin
        case (cpu_src_q)
            ppu_pkg::SRC_VRAM: cpu_bus.rdata = VRAM_RDATA;
            ppu_pkg::SRC_OAM:  cpu_bus.rdata = OAM_RDATA;
            default:           cpu_bus.rdata = 8'hFF;
        endcase
        case (ppu_src_q)
            ppu_pkg::SRC_VRAM: PPU_DATA_in = VRAM_RDATA;
            ppu_pkg::SRC_OAM:  PPU_DATA_in = OAM_RDATA;
            default:           PPU_DATA_in = 8'hFF;
        endcase
    end

endmodule

// File: tb/tb_vram_oam_arbiter.sv
// Scoreboard bench for vram_oam_arbiter; DMA scenarios run when OAM_DMA_EN is defined.
module tb_vram_oam_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        lcd_en;
    logic [1:0]  ppu_mode;
    logic [15:0] ppu_addr;
    logic        ppu_rd;
    logic [7:0]  ppu_data;
    logic [12:0] vram_addr;
    logic        vram_wr;
    logic [7:0]  vram_wdata;
    logic [7:0]  vram_rdata;
    logic [7:0]  oam_addr;
    logic        oam_wr;
    logic [7:0]  oam_wdata;
    logic [7:0]  oam_rdata;
    logic [15:0] dma_addr;
    logic        dma_rd;
    logic [7:0]  dma_data;
    logic        dma_active;

    vram_oam_arbiter_if cpu ();

    vram_oam_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .LCD_EN       (lcd_en),
        .PPU_MODE     (ppu_mode),
        .CPU_ADDR     (cpu.addr),
        .CPU_RD       (cpu.rd),
        .CPU_WR       (cpu.wr),
        .CPU_DATA_out (cpu.wdata),
        .CPU_DATA_in  (cpu.rdata),
        .PPU_ADDR     (ppu_addr),
        .PPU_RD       (ppu_rd),
        .PPU_DATA_in  (ppu_data),
        .VRAM_ADDR    (vram_addr),
        .VRAM_WR      (vram_wr),
        .VRAM_WDATA   (vram_wdata),
        .VRAM_RDATA   (vram_rdata),
        .OAM_ADDR     (oam_addr),
        .OAM_WR       (oam_wr),
        .OAM_WDATA    (oam_wdata),
        .OAM_RDATA    (oam_rdata),
        .DMA_ADDR     (dma_addr),
        .DMA_RD       (dma_rd),
        .DMA_DATA_in  (dma_data),
        .DMA_ACTIVE   (dma_active)
    );

    // Memory and DMA-source models, one-cycle read latency.
    logic [7:0] vmem [0:8191];
    logic [7:0] omem [0:255];
    always @(posedge clk) begin
        if (vram_wr) vmem[vram_addr] <= vram_wdata;
        if (oam_wr)  omem[oam_addr]  <= oam_wdata;
        vram_rdata <= vmem[vram_addr];
        oam_rdata  <= omem[oam_addr];
        dma_data   <= dma_addr[7:0] ^ {dma_addr[11:8], dma_addr[11:8]};
    end

    int checks = 0;
    int errors = 0;
    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    logic [15:0] oam_q [$];
    logic [15:0] dma_q [$];
    logic [20:0] vram_q [$];
    logic [7:0]  cpu_q [$];
    logic [7:0]  ppu_q [$];

    logic cpu_rd_prev, ppu_rd_prev;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_rd_prev <= 1'b0;
            ppu_rd_prev <= 1'b0;
        end else begin
            cpu_rd_prev <= cpu.rd;
            ppu_rd_prev <= ppu_rd;
        end
    end

    int act_cnt = 0;
    always @(negedge clk) begin
        if (dma_active) act_cnt++;
        if (oam_wr) begin
            if (oam_q.size() == 0) check("oam_wr_unexpected", 32'(oam_wr), 0);
            else check("oam_write", {oam_addr, oam_wdata}, oam_q.pop_front());
        end
        if (vram_wr) begin
            if (vram_q.size() == 0) check("vram_wr_unexpected", 32'(vram_wr), 0);
            else check("vram_write", {vram_addr, vram_wdata}, vram_q.pop_front());
        end
        if (dma_rd) begin
            if (dma_q.size() == 0) check("dma_rd_unexpected", 32'(dma_rd), 0);
            else check("dma_addr", dma_addr, dma_q.pop_front());
        end
        if (cpu_rd_prev) begin
            if (cpu_q.size() == 0) check("cpu_rd_unexpected", 32'(cpu_rd_prev), 0);
            else check("cpu_rdata", cpu.rdata, cpu_q.pop_front());
        end
        if (ppu_rd_prev) begin
            if (ppu_q.size() == 0) check("ppu_rd_unexpected", 32'(ppu_rd_prev), 0);
            else check("ppu_rdata", ppu_data, ppu_q.pop_front());
        end
    end

    task automatic cpu_cycle(input logic wr, input logic rd, input logic [15:0] a,
                             input logic [7:0] d);
        @(posedge clk);
        #1;
        cpu.addr = a; cpu.wr = wr; cpu.rd = rd; cpu.wdata = d;
        @(posedge clk);
        #1;
        cpu.addr = 16'h0; cpu.wr = 1'b0; cpu.rd = 1'b0; cpu.wdata = 8'h0;
    endtask

    task automatic ppu_read(input logic [15:0] a);
        @(posedge clk);
        #1;
        ppu_addr = a; ppu_rd = 1'b1;
        @(posedge clk);
        #1;
        ppu_addr = 16'h0; ppu_rd = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((dma_active || oam_q.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_timeout"}, 32'(n >= 2000), 0);
        @(posedge clk);
    endtask

    task automatic wait_oam(input logic [7:0] a);
        int n;
        bit hit;
        n = 0;
        hit = 1'b0;
        while (!hit && n < 2000) begin
            @(negedge clk);
            n++;
            hit = oam_wr && (oam_addr == a);
        end
        check("wait_oam_write", 32'(hit), 1);
    endtask

    initial begin
        int base;
        rst = 1'b1; lcd_en = 1'b0; ppu_mode = 2'd0; ppu_addr = 16'h0; ppu_rd = 1'b0;
        cpu.addr = 16'h0; cpu.rd = 1'b0; cpu.wr = 1'b0; cpu.wdata = 8'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_vram_wr", 32'(vram_wr), 0);
        check("rst_oam_wr", 32'(oam_wr), 0);
        check("rst_dma_rd", 32'(dma_rd), 0);
        check("rst_dma_active", 32'(dma_active), 0);
        check("rst_dma_addr", dma_addr, 0);
        check("rst_vram_addr", vram_addr, 0);
        check("rst_oam_addr", oam_addr, 0);
        check("rst_cpu_rdata", cpu.rdata, 8'hFF);
        check("rst_ppu_rdata", ppu_data, 8'hFF);
        @(posedge clk);
        #1 rst = 1'b0;

        // LCD off: CPU owns both memories, PPU reads return FF.
        lcd_en = 1'b0; ppu_mode = 2'd3;
        oam_q.push_back({8'h04, 8'hA1});
        cpu_cycle(1'b1, 1'b0, 16'hFE04, 8'hA1);
        oam_q.push_back({8'h20, 8'h77});
        cpu_cycle(1'b1, 1'b0, 16'hFE20, 8'h77);
        cpu_q.push_back(8'h77);
        cpu_cycle(1'b0, 1'b1, 16'hFE20, 8'h00);
        cpu_cycle(1'b1, 1'b0, 16'hFEA0, 8'h99);
        cpu_q.push_back(8'hFF);
        cpu_cycle(1'b0, 1'b1, 16'hC000, 8'h00);
        ppu_q.push_back(8'hFF);
        ppu_read(16'h8010);

        // DRAW: CPU locked out of VRAM.
        lcd_en = 1'b1; ppu_mode = 2'd3;
        @(posedge clk);
        #1 cpu.addr = 16'h8010; cpu.wr = 1'b1; cpu.wdata = 8'h5A;
        @(negedge clk);
        check("draw_vram_wr_blocked", 32'(vram_wr), 0);
        @(posedge clk);
        #1 cpu.addr = 16'h0; cpu.wr = 1'b0; cpu.wdata = 8'h0;
        cpu_q.push_back(8'hFF);
        cpu_cycle(1'b0, 1'b1, 16'h8010, 8'h00);

        // H_BLANK: CPU write then read; mode flips to DRAW right after the strobe.
        ppu_mode = 2'd0;
        vram_q.push_back({13'h0010, 8'h5A});
        @(posedge clk);
        #1 cpu.addr = 16'h8010; cpu.wr = 1'b1; cpu.wdata = 8'h5A;
        @(negedge clk);
        check("hblank_vram_addr", vram_addr, 13'h0010);
        @(posedge clk);
        #1 cpu.addr = 16'h0; cpu.wr = 1'b0; cpu.wdata = 8'h0;
        cpu_q.push_back(8'h5A);
        @(posedge clk);
        #1 cpu.addr = 16'h8010; cpu.rd = 1'b1;
        @(posedge clk);
        #1 cpu.addr = 16'h0; cpu.rd = 1'b0; ppu_mode = 2'd3;
        ppu_q.push_back(8'h5A);
        ppu_read(16'h8010);

        // SCAN: PPU owns OAM, CPU OAM read returns FF.
        ppu_mode = 2'd2;
        ppu_q.push_back(8'hA1);
        cpu_q.push_back(8'hFF);
        @(posedge clk);
        #1 ppu_addr = 16'hFE04; ppu_rd = 1'b1; cpu.addr = 16'hFE10; cpu.rd = 1'b1;
        @(negedge clk);
        check("scan_oam_addr", oam_addr, 8'h04);
        @(posedge clk);
        #1 ppu_addr = 16'h0; ppu_rd = 1'b0; cpu.addr = 16'h0; cpu.rd = 1'b0;
        repeat (2) @(posedge clk);

`ifdef OAM_DMA_EN
        ppu_mode = 2'd3;
        base = act_cnt;
        for (int i = 0; i < 160; i++) begin
            oam_q.push_back({8'(i), 8'(i) ^ 8'h11});
            dma_q.push_back(16'hC100 + 16'(i));
        end
        cpu_cycle(1'b1, 1'b0, 16'hFF46, 8'hC1);
        wait_idle("dma_c1");
        check("dma_active_cycles", act_cnt - base, 322);
        check("dma_c1_reads_done", dma_q.size(), 0);

        // Restart with an echo page while idx is 50.
        for (int i = 0; i < 50; i++) oam_q.push_back({8'(i), 8'(i) ^ 8'h11});
        for (int i = 0; i < 51; i++) dma_q.push_back(16'hC100 + 16'(i));
        cpu_cycle(1'b1, 1'b0, 16'hFF46, 8'hC1);
        wait_oam(8'd49);
        for (int i = 0; i < 160; i++) begin
            oam_q.push_back({8'(i), 8'(i) ^ 8'h22});
            dma_q.push_back(16'hC200 + 16'(i));
        end
        @(posedge clk);
        #1 cpu.addr = 16'hFF46; cpu.wr = 1'b1; cpu.wdata = 8'hE2;
        @(posedge clk);
        #1 cpu.addr = 16'h0; cpu.wr = 1'b0; cpu.wdata = 8'h0;
        check("restart_active", 32'(dma_active), 1);
        wait_idle("dma_restart");

        // Reset mid-transfer.
        for (int i = 0; i < 11; i++) begin
            oam_q.push_back({8'(i), 8'(i) ^ 8'h33});
            dma_q.push_back(16'hC300 + 16'(i));
        end
        cpu_cycle(1'b1, 1'b0, 16'hFF46, 8'hC3);
        wait_oam(8'd10);
        #2 rst = 1'b1;
        #1;
        check("rst_async_oam_wr", 32'(oam_wr), 0);
        check("rst_async_active", 32'(dma_active), 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (30) @(negedge clk);
        check("post_rst_idle", 32'(dma_active), 0);
        for (int i = 0; i < 160; i++) begin
            oam_q.push_back({8'(i), 8'(i) ^ 8'h44});
            dma_q.push_back(16'hC400 + 16'(i));
        end
        cpu_cycle(1'b1, 1'b0, 16'hFF46, 8'hC4);
        wait_idle("dma_after_rst");
`else
        base = act_cnt;
        cpu_cycle(1'b1, 1'b0, 16'hFF46, 8'hC1);
        repeat (20) @(negedge clk);
        @(posedge clk);
        check("nodma_active_cycles", act_cnt - base, 0);
        check("nodma_dma_addr", dma_addr, 0);
`endif

        repeat (3) @(posedge clk);
        check("oam_q_empty", oam_q.size(), 0);
        check("dma_q_empty", dma_q.size(), 0);
        check("vram_q_empty", vram_q.size(), 0);
        check("cpu_q_empty", cpu_q.size(), 0);
        check("ppu_q_empty", ppu_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vram_oam_arbiter.md
VRAM_OAM_ARBITER -- requirements
Module: vram_oam_arbiter

Interface
REQ-001 SHALL have parameter: OAM_BYTES, 160, bytes copied per OAM DMA transfer.
REQ-002 SHALL have parameter: DMA_DELAY, 2, idle cycles between the FF46 write and the first DMA read.
REQ-003 SHALL have ports:
- clk  in  1  clock; one clock only.
- rst  in  1  reset; asynchronous, active-high.
- LCD_EN  in  1  LCDC[7].
- PPU_MODE  in  2  H_BLANK=0, V_BLANK=1, SCAN=2, DRAW=3.
- CPU_ADDR  in  16  CPU address.
- CPU_RD  in  1  CPU read strobe.
- CPU_WR  in  1  CPU write strobe.
- CPU_DATA_out  in  8  CPU write data.
- CPU_DATA_in  out  8  CPU read data.
- PPU_ADDR  in  16  PPU fetch address.
- PPU_RD  in  1  PPU fetch strobe.
- PPU_DATA_in  out  8  PPU fetch data.
- VRAM_ADDR  out  13  VRAM address.
- VRAM_WR  out  1  VRAM write enable.
- VRAM_WDATA  out  8  VRAM write data.
- VRAM_RDATA  in  8  VRAM read data.
- OAM_ADDR  out  8  OAM address.
- OAM_WR  out  1  OAM write enable.
- OAM_WDATA  out  8  OAM write data.
- OAM_RDATA  in  8  OAM read data.
- DMA_ADDR  out  16  DMA source address.
- DMA_RD  out  1  DMA source read strobe.
- DMA_DATA_in  in  8  DMA source data.
- DMA_ACTIVE  out  1  DMA in progress.
- Read latency on every port: 1 cycle (data valid the cycle after the strobe).

Function
REQ-004 SHALL decode addresses: 16'h8000-9FFF as VRAM (index = addr[12:0]); 16'hFE00-FE9F as OAM (index = addr[7:0]); anything else as unmapped.
REQ-005 SHALL decide VRAM ownership each cycle: PPU when LCD_EN && PPU_MODE==DRAW, otherwise CPU.
REQ-006 SHALL decide OAM ownership each cycle, first match wins: DMA when DMA_ACTIVE; PPU when LCD_EN && PPU_MODE in {SCAN, DRAW}; otherwise CPU.
REQ-007 SHALL drop any write from a non-owner and SHALL return 8'hFF for any read from a non-owner or to an unmapped address.
REQ-008 SHALL capture the read-source select on the strobe cycle, so a mode change between strobe and data cycle does not alter the returned data.
REQ-009 SHALL make the DMA engine a state machine DMA_IDLE -> DMA_DELAY (DMA_DELAY cycles) -> DMA_READ <-> DMA_WRITE -> DMA_IDLE after byte OAM_BYTES-1.
- A CPU write to 16'hFF46 starts a transfer and latches page = CPU_DATA_out.
REQ-010 SHALL, in DMA_READ, drive DMA_RD=1 and DMA_ADDR={src_page, idx}; SHALL map pages 8'hE0-FF to 8'hC0-DF.
REQ-011 SHALL, in DMA_WRITE, drive OAM_WR=1, OAM_ADDR=idx, OAM_WDATA=DMA_DATA_in, then increment idx (8-bit, wraps only via restart).
- Total transfer: DMA_DELAY + 2*OAM_BYTES cycles.
REQ-012 SHALL restart a transfer on an FF46 write during an active one: idx=0, new page, re-enter DMA_DELAY; DMA_ACTIVE stays high.
REQ-013 SHALL hold DMA_ACTIVE high from the cycle after the FF46 write until the cycle after the last OAM write.
REQ-014 SHALL, when LCD_EN=0, grant the CPU full VRAM access and OAM access (except while DMA_ACTIVE); PPU reads then return 8'hFF.

Reset
REQ-015 SHALL on rst: DMA state DMA_IDLE, idx=0, DMA_ACTIVE=0, all write/read strobes 0, addresses 0, CPU_DATA_in=PPU_DATA_in=8'hFF.
REQ-016 SHALL abort an in-flight DMA on rst with no further OAM writes.

Configuration
REQ-017 SHALL, with OAM_DMA_EN defined, include the DMA engine as specified.
REQ-018 SHALL, without OAM_DMA_EN: ignore FF46 writes; DMA_RD=0, DMA_ADDR=0, DMA_ACTIVE=0 constantly; OAM ownership reduces to PPU/CPU.

Structure
REQ-019 SHALL take PPU_STATES_t, the DMA state enum, and the VRAM/OAM base/end address constants from shared package ppu_pkg.
REQ-020 SHALL implement the DMA engine as sub-module oam_dma_engine; arbitration muxing stays in the top.

Verification
REQ-021 SHALL cover these directed scenarios:
- LCD_EN=1, PPU_MODE=DRAW; CPU writes 8'h5A to 16'h8010 -> VRAM_WR stays 0; CPU read of 16'h8010 returns 8'hFF.
- PPU_MODE=H_BLANK; CPU writes 8'h5A to 16'h8010, then reads it -> VRAM_WR=1 with VRAM_ADDR=13'h0010; read returns VRAM_RDATA.
- PPU_MODE=SCAN; PPU_RD at 16'hFE04 -> OAM_ADDR=8'h04; CPU OAM read returns 8'hFF.
- CPU writes 8'hC1 to FF46 -> DMA_ADDR C100..C19F; 160 OAM writes idx 0..159; DMA_ACTIVE high for 2+320 cycles.
- FF46 rewritten with 8'hE2 at idx 50 -> restart at idx 0, source C200; OAM receives only C2xx data from then on.
- rst asserted mid-DMA -> OAM_WR, DMA_ACTIVE drop immediately (asynchronously); idx=0 after release.
